screen_reader: RTL and testbench
================================

SCREEN_READER -- requirements
Module: screen_reader

Interface
REQ-001 Parameter FB_ADDR, default 16'h0F00, byte address of framebuffer byte 0.
REQ-002 Parameter FB_BYTES, default 256, framebuffer size in bytes (64x32 pixels, 1 bpp, 8 bytes per row); fixed at 256 for this revision.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to scan out one full frame.
REQ-006 busy  output  1  high from accepted start until frame_done.
REQ-007 frame_done  output  1  one-cycle pulse after last pixel accepted.
REQ-008 mem_stall  input  1  high = memory owned by another initiator (gpu); no read issued.
REQ-009 mem_read  output  1  memory read strobe.
REQ-010 mem_write  output  1  tied 0.
REQ-011 mem_addr  output  16  memory byte address.
REQ-012 mem_write_byte  output  8  tied 8'h00.
REQ-013 mem_read_byte  input  8  memory read data, valid the cycle after mem_read.
REQ-014 pix_valid  output  1  pixel presented.
REQ-015 pix_ready  input  1  sink accepts pixel when high with pix_valid.
REQ-016 pix_data  output  1  pixel value (1 = lit).
REQ-017 pix_x  output  6  pixel column 0..63.
REQ-018 pix_y  output  5  pixel row 0..31.

Function
REQ-019 States IDLE, READ, LATCH, SHIFT, DONE; reset state IDLE.
REQ-020 IDLE: start=1 -> READ with byte index idx=0; otherwise stay.
REQ-021 READ: if mem_stall=0, assert mem_read=1, mem_addr=FB_ADDR+idx for exactly that cycle, -> LATCH; if mem_stall=1, mem_read=0, stay in READ.
REQ-022 LATCH: capture mem_read_byte into 8-bit shift register, bit counter=0, -> SHIFT; mem_read=0.
REQ-023 SHIFT: pix_valid=1; pix_data=shift register MSB; pix_x={idx[2:0],bit counter}; pix_y=idx[7:3].
REQ-024 Pixel ordering: byte MSB is leftmost pixel; bytes row-major, idx = y*8 + x/8.
REQ-025 Handshake: a pixel transfers on a cycle with pix_valid=1 and pix_ready=1; on transfer shift left by one and increment bit counter.
REQ-026 While pix_valid=1 and pix_ready=0, pix_data, pix_x, pix_y SHALL hold stable.
REQ-027 On transfer of bit 7: idx<255 -> idx+1, -> READ; idx=255 -> DONE.
REQ-028 DONE: frame_done=1 for one cycle, pix_valid=0, -> IDLE; busy falls in the same cycle frame_done is asserted high? No: busy=0 from the cycle after DONE.
REQ-029 busy=1 in READ, LATCH, SHIFT, DONE; busy=0 in IDLE.
REQ-030 start while busy=1 SHALL be ignored; no restart, no queued request.
REQ-031 start in the DONE cycle SHALL be ignored.
REQ-032 mem_addr = FB_ADDR+idx in all states except IDLE, where mem_addr=FB_ADDR; addition modulo 2^16.
REQ-033 pix_valid=0 in all states except SHIFT; mem_read=1 only in READ with mem_stall=0.
REQ-034 Minimum frame time with pix_ready held 1 and mem_stall held 0: 10 cycles per byte, 2560 cycles from start to frame_done, plus 1.
REQ-035 mem_stall is sampled only in READ; asserting it in LATCH or SHIFT has no effect on the byte already read.

Reset
REQ-036 rst_n=0 forces, asynchronously: state IDLE, idx=0, bit counter=0, shift register=0.
REQ-037 Output values under reset: busy=0, frame_done=0, mem_read=0, mem_addr=FB_ADDR, pix_valid=0, pix_data=0, pix_x=0, pix_y=0.
REQ-038 Reset mid-frame abandons the frame; no frame_done; next frame starts only on a new start after release.

Verification
REQ-039 mem[FB_ADDR]=8'hAA, rest 0, start, pix_ready=1 -> pixels (0..7,0) = 1,0,1,0,1,0,1,0; frame_done 2561 cycles after start; mem_write never 1.
REQ-040 mem[FB_ADDR+255]=8'h01 -> only pixel (63,31) =1; frame_done one cycle after its transfer; busy=0 next cycle.
REQ-041 pix_ready low 5 cycles on pixel (3,0) -> pix_data/pix_x/pix_y stable; no pixel dropped or duplicated; total 2048 transfers.
REQ-042 mem_stall=1 for 7 cycles in READ for idx=9 -> mem_read=0 for those cycles; then one read at FB_ADDR+9; frame_done delayed by 7 cycles.
REQ-043 rst_n=0 during idx=40 -> all outputs at reset values immediately; start pulses during busy ignored; next start scans from idx=0.

Source files
------------

// File: rtl/screen_reader_if.sv
// Bundles the screen reader's frame control, memory bus and pixel stream.
// master = the screen reader, slave = the memory/display side.
interface screen_reader_if;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        mem_stall;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_write_byte;
    logic [7:0]  mem_read_byte;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_data;
    logic [5:0]  pix_x;
    logic [4:0]  pix_y;

    modport master (
        input  start, mem_stall, mem_read_byte, pix_ready,
        output busy, frame_done, mem_read, mem_write, mem_addr, mem_write_byte,
               pix_valid, pix_data, pix_x, pix_y
    );

    modport slave (
        output start, mem_stall, mem_read_byte, pix_ready,
        input  busy, frame_done, mem_read, mem_write, mem_addr, mem_write_byte,
               pix_valid, pix_data, pix_x, pix_y
    );
endinterface

// File: rtl/screen_reader.sv
// Scans a 64x32 1bpp framebuffer out of shared memory as a valid/ready pixel
// stream, one byte (8 pixels, MSB leftmost) at a time.
module screen_reader #(
    parameter logic [15:0] FB_ADDR  = 16'h0F00,
    parameter int          FB_BYTES = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    screen_reader_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, SHIFT, DONE} state_t;

    localparam logic [7:0] IDX_LAST = 8'(FB_BYTES - 1);

    state_t     state_q;
    logic [7:0] idx_q;
    logic [7:0] sh_q;
    logic [2:0] bit_q;
    logic       xfer;

    assign xfer = (state_q == SHIFT) && bus.pix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            sh_q    <= 8'd0;
            bit_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        idx_q   <= 8'd0;
                        state_q <= READ;
                    end
                end
                // The gpu owns memory while mem_stall is high; wait here.
                READ: begin
                    if (!bus.mem_stall) state_q <= LATCH;
                end
                LATCH: begin
                    sh_q    <= bus.mem_read_byte;
                    bit_q   <= 3'd0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (xfer) begin
                        sh_q  <= {sh_q[6:0], 1'b0};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (idx_q == IDX_LAST) begin
                                state_q <= DONE;
                            end else begin
                                idx_q   <= idx_q + 8'd1;
                                state_q <= READ;
                            end
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state only, except the read strobe,
    // which must drop in the same cycle the gpu raises mem_stall.
    assign bus.busy           = (state_q != IDLE);
    assign bus.frame_done     = (state_q == DONE);
    assign bus.mem_read       = (state_q == READ) && !bus.mem_stall;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_write_byte = 8'h00;
    assign bus.mem_addr       = (state_q == IDLE) ? FB_ADDR : FB_ADDR + {8'h00, idx_q};
    assign bus.pix_valid      = (state_q == SHIFT);
    assign bus.pix_data       = (state_q == SHIFT) && sh_q[7];
    assign bus.pix_x          = {idx_q[2:0], bit_q};
    assign bus.pix_y          = idx_q[7:3];
endmodule

// File: tb/tb_screen_reader.sv
// Bench for screen_reader: memory model, pixel scoreboard, frame timing,
// pixel/memory stall corner cases and mid-frame reset.
module tb_screen_reader;
    localparam logic [15:0] FB = 16'h0F00;

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
        logic       d;
    } pix_t;

    typedef struct {
        int         idx;
        logic [7:0] val;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    screen_reader_if sif();

    screen_reader #(.FB_ADDR(FB), .FB_BYTES(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.master)
    );

    logic [7:0] mem [256];
    pix_t       sb[$];
    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, last_xfer_cyc = 0;
    int xfers = 0, reads = 0;
    bit wr_bad = 1'b0;
    bit hold_chk = 1'b0;
    logic [11:0] held = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (sif.mem_read) begin
            sif.mem_read_byte <= mem[8'(sif.mem_addr - FB)];
            reads++;
        end
    end

    // Pixel monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [11:0] cur;
        pix_t        e;
        cur = {sif.pix_x, sif.pix_y, sif.pix_data};
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (sif.pix_valid && sif.pix_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_pixel", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pixel", {20'h0, cur}, {20'h0, e});
                end
                xfers++;
                last_xfer_cyc = cyc;
            end
            if (hold_chk) chk("hold_stable", {20'h0, cur}, {20'h0, held});
            hold_chk = sif.pix_valid && !sif.pix_ready;
            held     = cur;
            if (sif.mem_write || sif.mem_write_byte != 8'h00) wr_bad = 1'b1;
        end
    end

    task automatic fill_sb();
        pix_t p;
        sb.delete();
        for (int i = 0; i < 256; i++)
            for (int b = 0; b < 8; b++) begin
                p.x = {i[2:0], b[2:0]};
                p.y = i[7:3];
                p.d = mem[i][7-b];
                sb.push_back(p);
            end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 sif.start = 1'b1;
        @(negedge clk); start_cyc = cyc;
        @(posedge clk); #1 sif.start = 1'b0;
    endtask

    task automatic run_frame(input int exp_lat, input bit start_in_done, input bit extra_starts);
        int n;
        fill_sb();
        xfers = 0; reads = 0; wr_bad = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", {31'h0, sif.busy}, 32'd1);
        n = 0;
        while (!sif.frame_done && n < 3000) begin
            sif.start = extra_starts && (n % 300 == 7) && (n < 2500);
            @(negedge clk);
            n++;
        end
        sif.start = 1'b0;
        chk("frame_done_seen", {31'h0, sif.frame_done}, 32'd1);
        chk("frame_latency", cyc - start_cyc, exp_lat);
        chk("done_after_last_xfer", cyc - last_xfer_cyc, 32'd1);
        if (start_in_done) begin
            sif.start = 1'b1;
            @(posedge clk); #1 sif.start = 1'b0;
        end
        @(negedge clk);
        chk("busy_after_done", {30'h0, sif.busy, sif.frame_done}, 32'd0);
        @(negedge clk);
        chk("idle_after_done", {30'h0, sif.busy, sif.frame_done}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        chk("xfer_count", xfers, 32'd2048);
        chk("read_count", reads, 32'd256);
        chk("no_mem_write", {31'h0, wr_bad}, 32'd0);
    endtask

    task automatic ready_inject();
        bit found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(posedge clk); #1;
            if (sif.pix_valid && sif.pix_x == 6'd3 && sif.pix_y == 5'd0) begin
                sif.pix_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 sif.pix_ready = 1'b1;
                found = 1'b1;
            end
        end
        chk("ready_inject_found", {31'h0, found}, 32'd1);
    endtask

    task automatic stall_inject();
        bit found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(posedge clk); #1;
            if (sif.busy && !sif.pix_valid && sif.mem_addr == FB + 16'd9) begin
                sif.mem_stall = 1'b1;
                for (int k = 0; k < 7; k++) begin
                    if (k > 0) begin @(posedge clk); #1; end
                    @(negedge clk);
                    chk("stall_no_read", {31'h0, sif.mem_read}, 32'd0);
                end
                @(posedge clk); #1 sif.mem_stall = 1'b0;
                #1 chk("read_after_stall", {15'h0, sif.mem_read, sif.mem_addr}, {15'h0, 1'b1, FB + 16'd9});
                found = 1'b1;
            end
        end
        chk("stall_inject_found", {31'h0, found}, 32'd1);
    endtask

    function automatic logic [31:0] out_vec();
        return {sif.busy, sif.frame_done, sif.mem_read, sif.mem_addr,
                sif.pix_valid, sif.pix_data, sif.pix_x, sif.pix_y};
    endfunction

    localparam logic [31:0] RST_VEC = {3'b000, FB, 2'b00, 6'd0, 5'd0};

    initial begin
        vec_t tbl[4];
        bit   hit;
        tbl[0] = '{idx: 0,   val: 8'hAA, lat: 2561};
        tbl[1] = '{idx: 255, val: 8'h01, lat: 2561};
        tbl[2] = '{idx: 100, val: 8'hFF, lat: 2561};
        tbl[3] = '{idx: 37,  val: 8'h5A, lat: 2561};

        sif.start = 1'b0; sif.mem_stall = 1'b0; sif.pix_ready = 1'b1;
        sif.mem_read_byte = 8'h00;
        #3 chk("reset_outputs", out_vec(), RST_VEC);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", out_vec(), RST_VEC);

        for (int i = 0; i < 4; i++) begin
            foreach (mem[j]) mem[j] = 8'h00;
            mem[tbl[i].idx] = tbl[i].val;
            run_frame(tbl[i].lat, i == 1, i == 2);
        end

        // Sink back-pressure on pixel (3,0) for 5 cycles.
        foreach (mem[j]) mem[j] = 8'($urandom);
        fork
            run_frame(2566, 1'b0, 1'b0);
            ready_inject();
        join

        // gpu holds memory for 7 cycles when byte 9 is due.
        foreach (mem[j]) mem[j] = 8'($urandom);
        fork
            run_frame(2568, 1'b0, 1'b0);
            stall_inject();
        join

        // Reset in the middle of byte 40.
        foreach (mem[j]) mem[j] = 8'($urandom);
        fill_sb();
        pulse_start();
        hit = 1'b0;
        for (int n = 0; n < 1000 && !hit; n++) begin
            @(posedge clk); #1;
            if (sif.pix_valid && sif.pix_y == 5'd5 && sif.pix_x == 6'd0) hit = 1'b1;
        end
        chk("reached_idx40", {31'h0, hit}, 32'd1);
        rst_n = 1'b0;
        #1 chk("async_reset_outputs", out_vec(), RST_VEC);
        sif.start = 1'b1;
        @(posedge clk); #1 sif.start = 1'b0;
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        hit = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (sif.busy || sif.frame_done) hit = 1'b1;
        end
        chk("no_restart_after_reset", {31'h0, hit}, 32'd0);
        run_frame(2561, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
